// File: rtl/dtm_pkg.sv
// rtl/dtm_pkg.sv - debug-transport frame constants and host FSM encoding shared with the DTM side
package dtm_pkg;

    localparam logic [7:0] DTM_MAGIC = 8'h5A;

    localparam logic [2:0] IDX_MAGIC = 3'd0;
    localparam logic [2:0] IDX_ADDR  = 3'd1;
    localparam logic [2:0] IDX_D0    = 3'd2;
    localparam logic [2:0] IDX_D1    = 3'd3;
    localparam logic [2:0] IDX_D2    = 3'd4;
    localparam logic [2:0] IDX_D3    = 3'd5;
    localparam logic [2:0] IDX_CSUM  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } host_state_t;

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [7:0] hdr,
                                              input logic [31:0] data, input logic [7:0] csum);
        case (idx)
            IDX_MAGIC: return DTM_MAGIC;
            IDX_ADDR:  return hdr;
            IDX_D0:    return data[7:0];
            IDX_D1:    return data[15:8];
            IDX_D2:    return data[23:16];
            IDX_D3:    return data[31:24];
            default:   return csum;
        endcase
    endfunction

endpackage

// File: rtl/dmi_frame_parser.sv
// rtl/dmi_frame_parser.sv - response frame parser: hunts for magic, collects addr, LE data and csum
module dmi_frame_parser
    import dtm_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [7:0]  exp_addr,
    output logic        done,
    output logic [31:0] data,
    output logic        csum_ok,
    output logic        addr_ok
);

    logic [2:0]  pos;
    logic [7:0]  acc;
    logic [7:0]  addr_q;
    logic [31:0] data_q;

    // Once past the hunt, a magic byte is ordinary payload; there is no resync.
    always_ff @(posedge clk) begin
        if (!resetn || !enable) begin
            pos    <= IDX_MAGIC;
            acc    <= 8'h00;
            addr_q <= 8'h00;
            data_q <= 32'h0;
        end else if (rx_valid) begin
            case (pos)
                IDX_MAGIC: begin
                    if (rx_data == DTM_MAGIC)
                        pos <= IDX_ADDR;
                end
                IDX_CSUM: begin
                    pos <= IDX_MAGIC;
                    acc <= 8'h00;
                end
                default: begin
                    pos <= pos + 3'd1;
                    acc <= acc ^ rx_data;
                    if (pos == IDX_ADDR)
                        addr_q <= rx_data;
                    else
                        data_q <= {rx_data, data_q[31:8]};
                end
            endcase
        end
    end

    assign done    = enable && rx_valid && (pos == IDX_CSUM);
    assign data    = data_q;
    assign csum_ok = (acc == rx_data);
    assign addr_ok = (addr_q == exp_addr);

endmodule

// File: rtl/dmi_uart_host.sv
// rtl/dmi_uart_host.sv - DMI request to byte-stream frame host; read timeout under DMI_HOST_TIMEOUT_EN
module dmi_uart_host
    import dtm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [6:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    host_state_t state, state_d;

    logic        wr_q;
    logic [6:0]  addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  idx;
    logic [2:0]  idx_nxt;
    logic [7:0]  csum;
    logic [7:0]  byte_nxt;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        accept;
    logic        tx_hs;
    logic        last_hs;
    logic        timeout;

    logic        p_done;
    logic [31:0] p_data;
    logic        p_csum_ok;
    logic        p_addr_ok;

    assign accept   = (state == ST_IDLE) && req_valid;
    assign tx_hs    = (state == ST_SEND) && tx_valid && tx_ready;
    assign last_hs  = tx_hs && (idx == IDX_CSUM);
    assign idx_nxt  = idx + 3'd1;
    assign byte_nxt = frame_byte(idx_nxt, {wr_q, addr_q}, wdata_q, csum);

`ifdef DMI_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk) begin
        if (!resetn || state != ST_WAIT_RSP)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end

    assign timeout = (state == ST_WAIT_RSP) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d   = state;
        req_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = ST_SEND;
            end
            ST_SEND: begin
                if (last_hs)
                    state_d = wr_q ? ST_DONE : ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (p_done || timeout)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The next byte is loaded on the handshake edge so tx_valid can stay high back-to-back.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_q     <= 1'b0;
            addr_q   <= 7'h0;
            wdata_q  <= 32'h0;
            idx      <= IDX_MAGIC;
            csum     <= 8'h00;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else if (accept) begin
            wr_q     <= req_write;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            idx      <= IDX_MAGIC;
            csum     <= 8'h00;
            tx_valid <= 1'b1;
            tx_data  <= DTM_MAGIC;
        end else if (tx_hs) begin
            if (idx == IDX_CSUM) begin
                tx_valid <= 1'b0;
            end else begin
                idx     <= idx_nxt;
                tx_data <= byte_nxt;
                if (idx_nxt != IDX_CSUM)
                    csum <= csum ^ byte_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else if (last_hs && wr_q) begin
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else if (state == ST_WAIT_RSP && p_done) begin
            err_q   <= !(p_csum_ok && p_addr_ok);
            rdata_q <= (p_csum_ok && p_addr_ok) ? p_data : 32'h0;
        end else if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
        end
    end

    dmi_frame_parser u_parser (
        .clk      (clk),
        .resetn   (resetn),
        .enable   (state == ST_WAIT_RSP),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .exp_addr ({1'b0, addr_q}),
        .done     (p_done),
        .data     (p_data),
        .csum_ok  (p_csum_ok),
        .addr_ok  (p_addr_ok)
    );

    assign rsp_valid = (state == ST_DONE);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_dmi_uart_host.sv
// tb/tb_dmi_uart_host.sv - table-driven scoreboard bench for dmi_uart_host
module tb_dmi_uart_host;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [6:0]  req_addr = 7'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_q[$];
    logic [32:0] rsp_q[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  tx_csum;
        logic [7:0]  rsp_addr;
        logic [31:0] rsp_data;
        logic        bad_csum;
        int          stall;
        logic        noise;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    dmi_uart_host #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && tx_valid)
                chk("tx_data_stable", {24'h0, tx_data}, {24'h0, prev_data});
            prev_stall <= tx_valid && !tx_ready;
            prev_data  <= tx_data;
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0)
                    chk("tx_unexpected_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
                else
                    chk("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", {31'h0, rsp_valid}, 32'h0);
                end else begin
                    logic [32:0] e;
                    e = rsp_q.pop_front();
                    chk("rsp_err", {31'h0, rsp_err}, {31'h0, e[32]});
                    chk("rsp_rdata", rsp_rdata, e[31:0]);
                end
            end
        end
    end

    task automatic send_req(input vec_t v);
        logic [7:0] fr[7];
        fr[0] = 8'h5A;
        fr[1] = {v.wr, v.addr};
        fr[2] = v.wdata[7:0];
        fr[3] = v.wdata[15:8];
        fr[4] = v.wdata[23:16];
        fr[5] = v.wdata[31:24];
        fr[6] = v.tx_csum;
        for (int i = 0; i < 7; i++) tx_q.push_back(fr[i]);
        rsp_q.push_back({v.exp_err, v.exp_rdata});
        @(negedge clk);
        chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = 32'hCAFE_F00D;
        for (int b = 0; b < 7; b++) begin
            for (int s = 0; s < v.stall; s++) begin
                tx_ready = 1'b0;
                if (v.noise) begin rx_valid = 1'b1; rx_data = 8'h5A; end
                @(negedge clk);
                chk("req_ready_busy", {31'h0, req_ready}, 32'h0);
                @(posedge clk); #1;
                rx_valid = 1'b0;
            end
            tx_ready = 1'b1;
            if (v.noise) begin rx_valid = 1'b1; rx_data = 8'h5A; end
            @(negedge clk);
            chk("tx_valid_send", {31'h0, tx_valid}, 32'h1);
            chk("req_ready_busy", {31'h0, req_ready}, 32'h0);
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
        tx_ready = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] r[6];
        send_req(v);
        if (v.wr) begin
            @(negedge clk);
            chk("wr_rsp_latency", {31'h0, rsp_valid}, 32'h1);
        end else begin
            @(negedge clk);
            chk("tx_valid_after_frame", {31'h0, tx_valid}, 32'h0);
            if (v.noise) begin
                send_rx(8'h00);
                send_rx(8'hFF);
                send_rx(8'h33);
            end
            r[0] = v.rsp_addr;
            r[1] = v.rsp_data[7:0];
            r[2] = v.rsp_data[15:8];
            r[3] = v.rsp_data[23:16];
            r[4] = v.rsp_data[31:24];
            r[5] = r[0] ^ r[1] ^ r[2] ^ r[3] ^ r[4] ^ {7'h0, v.bad_csum};
            send_rx(8'h5A);
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                chk("rsp_early", {31'h0, rsp_valid}, 32'h0);
                @(posedge clk); #1;
                send_rx(r[i]);
            end
            @(negedge clk);
            chk("rd_rsp_latency", {31'h0, rsp_valid}, 32'h1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("rsp_one_cycle", {31'h0, rsp_valid}, 32'h0);
        chk("req_ready_after", {31'h0, req_ready}, 32'h1);
        chk("scoreboard_drained", tx_q.size() + rsp_q.size(), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 7'h10, 32'h8000_0001, 8'h11, 8'h00, 32'h0,         1'b0, 0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 7'h11, 32'h0,         8'h11, 8'h11, 32'h1234_5678, 1'b0, 0, 1'b0, 1'b0, 32'h1234_5678};
        vecs[2] = '{1'b0, 7'h11, 32'h0,         8'h11, 8'h11, 32'h1234_5678, 1'b1, 0, 1'b0, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 7'h11, 32'h0,         8'h11, 8'h12, 32'h1234_5678, 1'b0, 0, 1'b0, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 7'h11, 32'h0,         8'h11, 8'h11, 32'h1234_5678, 1'b0, 0, 1'b1, 1'b0, 32'h1234_5678};
        vecs[5] = '{1'b1, 7'h7F, 32'hDEAD_BEEF, 8'hDD, 8'h00, 32'h0,         1'b0, 3, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 7'h05, 32'hA5A5_A5A5, 8'h05, 8'h05, 32'h5A5A_5A5A, 1'b0, 3, 1'b1, 1'b0, 32'h5A5A_5A5A};

        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
        chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("reset_tx_data", {24'h0, tx_data}, 32'h0);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset in the middle of a frame.
        for (int i = 0; i < 7; i++) tx_q.push_back(8'h00);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h10; req_wdata = 32'h8000_0001;
        @(posedge clk); #1;
        req_valid = 1'b0;
        tx_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b0;
        tx_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_after_req_ready", {31'h0, req_ready}, 32'h1);
            chk("rst_after_tx_valid", {31'h0, tx_valid}, 32'h0);
            chk("rst_after_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        end
        run_vec(vecs[0]);
        run_vec(vecs[1]);

`ifdef DMI_HOST_TIMEOUT_EN
        begin
            vec_t t;
            t = vecs[1];
            t.exp_err   = 1'b1;
            t.exp_rdata = 32'h0;
            send_req(t);
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                chk("timeout_early", {31'h0, rsp_valid}, 32'h0);
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk("timeout_rsp", {31'h0, rsp_valid}, 32'h1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("timeout_one_cycle", {31'h0, rsp_valid}, 32'h0);
            chk("timeout_drained", tx_q.size() + rsp_q.size(), 32'h0);
            run_vec(vecs[1]);
        end
`endif

        repeat (3) @(posedge clk);
        chk("final_drained", tx_q.size() + rsp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
